// File: rtl/vending_ctrl.sv
// Soda vending controller: coin credit, dispense pulse and coin-by-coin change return.
// Optional cancel/refund path enabled by defining VENDING_CTRL_REFUND_EN.
module vending_ctrl #(
  parameter int unsigned PRICE = 5,
  parameter int unsigned CW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in1,
  input  logic          in2,
  input  logic          in5,
  input  logic          cancel,
  input  logic          chg_ack,
  output logic          soda,
  output logic          chg1,
  output logic          chg2,
  output logic          coin_rej,
  output logic          busy,
  output logic [CW-1:0] credit
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE, REFUND} state_t;

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          soda_q, soda_d;
  logic          chg1_q, chg1_d;
  logic          chg2_q, chg2_d;
  logic          rej_q, rej_d;
  logic          busy_q, busy_d;

  logic [1:0]    n_coins;
  logic          any_coin;
  logic [CW-1:0] coin_val;
  logic [CW-1:0] credit_sum;
  logic [CW-1:0] credit_acc;
  logic          refund_req;

`ifdef VENDING_CTRL_REFUND_EN
  assign refund_req = cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign refund_req    = 1'b0;
`endif

  assign n_coins    = {1'b0, in1} + {1'b0, in2} + {1'b0, in5};
  assign any_coin   = in1 | in2 | in5;
  assign coin_val   = in5 ? CW'(5) : (in2 ? CW'(2) : CW'(1));
  assign credit_sum = credit_q + coin_val;
  assign credit_acc = (n_coins == 2'd1) ? credit_sum : credit_q;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    soda_d   = 1'b0;
    chg1_d   = chg1_q;
    chg2_d   = chg2_q;
    rej_d    = 1'b0;
    case (state_q)
      IDLE: begin
        chg1_d = 1'b0;
        chg2_d = 1'b0;
        if (n_coins > 2'd1) rej_d = 1'b1;
        // A completing purchase wins over a simultaneous cancel; the remainder comes back as change.
        if ((n_coins == 2'd1) && (credit_sum >= PRICE_C)) begin
          credit_d = credit_sum - PRICE_C;
          soda_d   = 1'b1;
          state_d  = VEND;
        end else begin
          credit_d = credit_acc;
          if (refund_req && (credit_acc != '0)) begin
            state_d = REFUND;
            chg2_d  = (credit_acc >= CW'(2));
            chg1_d  = (credit_acc == CW'(1));
          end
        end
      end
      VEND: begin
        if (any_coin) rej_d = 1'b1;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
          state_d = CHANGE;
          chg2_d  = (credit_q >= CW'(2));
          chg1_d  = (credit_q == CW'(1));
        end
      end
      CHANGE, REFUND: begin
        if (any_coin) rej_d = 1'b1;
        if (chg1_q || chg2_q) begin
          if (chg_ack) begin
            credit_d = credit_q - (chg2_q ? CW'(2) : CW'(1));
            chg1_d   = 1'b0;
            chg2_d   = 1'b0;
            if (credit_d == '0) state_d = IDLE;
          end
        end else begin
          // Gap cycle after an acknowledge: raise the next coin request.
          chg2_d = (credit_q >= CW'(2));
          chg1_d = (credit_q == CW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      soda_q   <= 1'b0;
      chg1_q   <= 1'b0;
      chg2_q   <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      soda_q   <= soda_d;
      chg1_q   <= chg1_d;
      chg2_q   <= chg2_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
    end
  end

  assign soda     = soda_q;
  assign chg1     = chg1_q;
  assign chg2     = chg2_q;
  assign coin_rej = rej_q;
  assign busy     = busy_q;
  assign credit   = credit_q;

endmodule
